// File: rtl/des_pkg.sv
`default_nettype none
// ============================================================================
// Module      : des_pkg
// Description : Shared DES types, permutation tables (FIPS 1-based bit
//               positions), key-schedule shift table and rotate helpers.
// Revision    : 1.0 - initial release
// ============================================================================
package des_pkg;

  typedef logic [55:0] cd_t;      // {C[27:0], D[27:0]}
  typedef logic [47:0] subkey_t;  // FIPS bit 1 = [47]

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } state_e;

  // State encodings used by the legacy-compatible FSM register
  localparam logic [0:0] IDLE   = ST_IDLE;
  localparam logic [0:0] ACTIVE = ST_ACTIVE;

  // PC-1: output bit i+1 takes key bit PC1[i] (FIPS numbering)
  localparam int PC1 [56] = '{
    57, 49, 41, 33, 25, 17,  9,
     1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27,
    19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,
     7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29,
    21, 13,  5, 28, 20, 12,  4
  };

  // PC-2: output bit i+1 takes CD bit PC2[i] (FIPS numbering)
  localparam int PC2 [48] = '{
    14, 17, 11, 24,  1,  5,
     3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8,
    16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55,
    30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53,
    46, 42, 50, 36, 29, 32
  };

  // Rotation amount for rounds 1..16, stored at index 0..15
  localparam logic [1:0] SHIFT [16] = '{
    2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
    2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1
  };

  // 28-bit circular rotate left by 1 or 2
  function automatic logic [27:0] rotl28(input logic [27:0] x, input logic [1:0] n);
    return (n == 2'd2) ? {x[25:0], x[27:26]} : {x[26:0], x[27]};
  endfunction

  // 28-bit circular rotate right by 1 or 2
  function automatic logic [27:0] rotr28(input logic [27:0] x, input logic [1:0] n);
    return (n == 2'd2) ? {x[1:0], x[27:2]} : {x[0], x[27:1]};
  endfunction

endpackage
`default_nettype wire

// File: rtl/des_key_schedule_if.sv
`default_nettype none
// ============================================================================
// Module      : des_key_schedule_if
// Description : Load/next handshake between the round controller and the
//               DES key schedule, plus the round-key outputs.
// Revision    : 1.0 - initial release
// ============================================================================
interface des_key_schedule_if;
  import des_pkg::*;

  logic      load;
  logic [63:0] key;
  logic      encrypt;
  logic      next;
  subkey_t   subkey;
  logic      subkey_valid;
  logic [3:0] round;
  logic      last_round;
  logic      busy;
  logic      error;

  // Round controller side
  modport master (
    output load, key, encrypt, next,
    input  subkey, subkey_valid, round, last_round, busy, error
  );

  // Key schedule side
  modport slave (
    input  load, key, encrypt, next,
    output subkey, subkey_valid, round, last_round, busy, error
  );

endinterface
`default_nettype wire

// File: rtl/des_pc2.sv
`default_nettype none
// ============================================================================
// Module      : des_pc2
// Description : Combinational PC-2 permutation, 56-bit CD to 48-bit subkey.
// Revision    : 1.0 - initial release
// ============================================================================
module des_pc2
  import des_pkg::*;
(
  input  cd_t     cd,
  output subkey_t subkey
);

  // FIPS position p maps to vector bit (width - p)
  for (genvar i = 0; i < 48; i++) begin : g_pc2
    localparam int SRC = 56 - PC2[i];
    assign subkey[47-i] = cd[SRC];
  end

endmodule
`default_nettype wire

// File: rtl/des_key_schedule.sv
`default_nettype none
// ============================================================================
// Module      : des_key_schedule
// Description : Issues the sixteen DES round keys one per 'next', forward
//               order with left rotations or reverse order with right
//               rotations, with optional odd-parity key check at load.
// Revision    : 1.0 - initial release
// ============================================================================
module des_key_schedule
  import des_pkg::*;
#(
  parameter int CHECK_PARITY = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  des_key_schedule_if.slave ks
);

  logic [0:0] r_state;
  cd_t        r_cd;
  cd_t        r_c0d0;
  logic [3:0] r_round;
  logic       r_dir;
  logic       r_error;

  cd_t        w_pc1;
  cd_t        w_cd_load;
  cd_t        w_cd_step;
  subkey_t    w_pc2;
  logic [7:0] w_byte_odd;
  logic       w_key_ok;
  logic [3:0] w_shift_idx;
  logic [1:0] w_shift;
  logic       w_valid;

  // PC-1 straight from the key pins; parity bits fall out naturally
  for (genvar i = 0; i < 56; i++) begin : g_pc1
    localparam int SRC = 64 - PC1[i];
    assign w_pc1[55-i] = ks.key[SRC];
  end

  for (genvar b = 0; b < 8; b++) begin : g_parity
    assign w_byte_odd[b] = ^ks.key[8*b +: 8];
  end

  assign w_key_ok = (CHECK_PARITY == 0) || (&w_byte_odd);

  // Encrypt starts at C1D1; decrypt starts at C0D0 which equals C16D16
  assign w_cd_load = ks.encrypt ? {rotl28(w_pc1[55:28], 2'd1), rotl28(w_pc1[27:0], 2'd1)}
                                : w_pc1;

  // Forward uses SHIFT of the round being entered; reverse undoes the
  // shift that produced the key currently held
  assign w_shift_idx = r_dir ? (r_round + 4'd1) : (4'd15 - r_round);
  assign w_shift     = SHIFT[w_shift_idx];

  assign w_cd_step = r_dir ? {rotl28(r_cd[55:28], w_shift), rotl28(r_cd[27:0], w_shift)}
                           : {rotr28(r_cd[55:28], w_shift), rotr28(r_cd[27:0], w_shift)};

  des_pc2 u_pc2 (
    .cd     (r_cd),
    .subkey (w_pc2)
  );

  assign w_valid         = (r_state == ACTIVE);
  assign ks.subkey       = w_valid ? w_pc2 : '0;
  assign ks.subkey_valid = w_valid;
  assign ks.round        = r_round;
  assign ks.last_round   = w_valid && (r_round == 4'd15);
  assign ks.busy         = w_valid;
  assign ks.error        = r_error;

  // Schedule FSM: load beats next; rejected loads and stray nexts pulse error
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cd    <= '0;
      r_c0d0  <= '0;
      r_round <= 4'd0;
      r_dir   <= 1'b0;
      r_error <= 1'b0;
    end else begin
      r_error <= 1'b0;
      if (ks.load) begin
        if (w_key_ok) begin
          r_state <= ACTIVE;
          r_dir   <= ks.encrypt;
          r_round <= 4'd0;
          r_cd    <= w_cd_load;
          r_c0d0  <= w_pc1;
        end else begin
          r_error <= 1'b1;
        end
      end else if (ks.next) begin
        if (r_state == IDLE) begin
          r_error <= 1'b1;
        end else if (r_round == 4'd15) begin
          r_state <= IDLE;
          r_round <= 4'd0;
        end else begin
          r_round <= r_round + 4'd1;
          r_cd    <= w_cd_step;
        end
      end
    end
  end

  // Sixteen forward rotations total 28 per half, so K16 sits on C0D0
  always_ff @(posedge clk) begin
    if (rst_n && (r_state == ACTIVE) && r_dir && (r_round == 4'd15)) begin
      assert (r_cd == r_c0d0);
    end
  end

endmodule
`default_nettype wire
